// File: rtl/sv_mod_counter.sv
// ---------------------------------------------------------------------------
// sv_mod_counter
//
// Purpose:
//   Up/down modulo counter with terminal value MAX. At a boundary (counting
//   up from MAX or down from 0) the counter either wraps (SATURATE=0) or
//   holds (SATURATE=1). Each boundary event raises a one-cycle tc pulse and
//   sets a sticky ovf flag. Synchronous clear and clamped load take priority
//   over counting.
//
// Parameters:
//   WIDTH    - counter width in bits, 2..32
//   MAX      - terminal (modulo) value, 1..2**WIDTH-1
//   SATURATE - 0 = wrap at boundaries, 1 = hold at boundaries
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   en       in   1      count enable, one step per enabled cycle
//   up_dn    in   1      direction, 1 = up, 0 = down
//   clr      in   1      synchronous clear (highest priority)
//   load     in   1      synchronous load of load_val (clamped to MAX)
//   load_val in   WIDTH  value to load
//   ovf_clr  in   1      clears the sticky ovf flag
//   count    out  WIDTH  registered counter value
//   tc       out  1      registered terminal-count pulse
//   ovf      out  1      registered sticky boundary-event flag
// ---------------------------------------------------------------------------
module sv_mod_counter #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam longint unsigned LIMIT = (64'd1 << WIDTH) - 64'd1;

    // Reject illegal parameterisations at elaboration time.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("sv_mod_counter: WIDTH must be in 2..32");
    end
    if (MAX < 64'd1 || MAX > LIMIT) begin : g_bad_max
        $error("sv_mod_counter: MAX must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic             at_top;
    logic             at_bottom;
    logic             boundary;
    logic [WIDTH-1:0] count_next;

    assign at_top    = (count == MAX_V);
    assign at_bottom = (count == ZERO);

    // A boundary event is an enabled step that would leave [0, MAX]; clr and
    // load pre-empt counting, so they can never produce one.
    assign boundary = en && !clr && !load &&
                      ((up_dn && at_top) || (!up_dn && at_bottom));

    // Next count in priority order clr > load > en > hold. The increment and
    // decrement are only taken strictly inside the range, so the arithmetic
    // never leaves [0, MAX].
    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = ZERO;
        end else if (load) begin
            count_next = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (!at_top)
                    count_next = count + ONE;
                else if (SATURATE == 0)
                    count_next = ZERO;
            end else begin
                if (!at_bottom)
                    count_next = count - ONE;
                else if (SATURATE == 0)
                    count_next = MAX_V;
            end
        end
    end

    // ovf: a boundary event on the same edge overrides ovf_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= ZERO;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            tc    <= boundary;
            ovf   <= boundary | (ovf & ~ovf_clr);
        end
    end

endmodule
